// File: rtl/minterm_extractor.sv
// Scans a latched truth table and streams the indices of its set bits over a
// valid/ready handshake. Define MINTERM_MAXTERM_EN to add maxterm_sel (emit cleared bits).
module minterm_extractor #(
    parameter int N_VARS = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
`ifdef MINTERM_MAXTERM_EN
    input  logic                 maxterm_sel,
`endif
    input  logic [2**N_VARS-1:0] table_in,
    output logic                 busy,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [N_VARS-1:0]    out_index,
    output logic                 out_last,
    output logic                 done,
    output logic [N_VARS:0]      count
);

    localparam int W = 2**N_VARS;
    localparam logic [N_VARS-1:0] IDX_MAX = {N_VARS{1'b1}};

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t            state, state_nxt;
    logic [W-1:0]      tbl;
    logic [W-1:0]      sel_tbl;
    logic [W-1:0]      above;
    logic [N_VARS-1:0] idx;
    logic [N_VARS:0]   cnt;
    logic              advance;
    logic              xfer;

`ifdef MINTERM_MAXTERM_EN
    logic inv_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            inv_q <= 1'b0;
        else if (state == IDLE && start)
            inv_q <= maxterm_sel;
    end

    assign sel_tbl = tbl ^ {W{inv_q}};
`else
    assign sel_tbl = tbl;
`endif

    // NOTE: non-blocking (<=) in clocked blocks so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        out_valid = 1'b0;
        done      = 1'b0;
        advance   = 1'b0;
        case (state)
            IDLE: begin
                if (start)
                    state_nxt = SCAN;
            end
            SCAN: begin
                busy      = 1'b1;
                out_valid = sel_tbl[idx];
                // A cleared bit moves on at once; a set bit waits for the consumer.
                advance   = !out_valid || out_ready;
                if (advance && idx == IDX_MAX)
                    state_nxt = DONE;
            end
            DONE: begin
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign xfer      = out_valid && out_ready;
    assign above     = (sel_tbl >> idx) >> 1;
    assign out_last  = out_valid && (above == '0);
    assign out_index = out_valid ? idx : '0;
    assign count     = cnt;

    // NOTE: the latched table is a plain register, so it is reset like any other state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tbl <= '0;
            idx <= '0;
            cnt <= '0;
        end else if (state == IDLE && start) begin
            tbl <= table_in;
            idx <= '0;
            cnt <= '0;
        end else if (state == SCAN && advance) begin
            // idx parks on the last entry instead of wrapping.
            if (idx != IDX_MAX)
                idx <= idx + 1'b1;
            if (xfer)
                cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_minterm_extractor.sv
// Table-driven bench for minterm_extractor (N_VARS=4) plus hand sequences for
// start-ignored, reset-abort and (with MINTERM_MAXTERM_EN) maxterm selection.
module tb_minterm_extractor;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] table_in;
    logic        busy;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_index;
    logic        out_last;
    logic        done;
    logic [4:0]  count;
`ifdef MINTERM_MAXTERM_EN
    logic        maxterm_sel;
`endif

    minterm_extractor #(.N_VARS(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
`ifdef MINTERM_MAXTERM_EN
        .maxterm_sel(maxterm_sel),
`endif
        .table_in  (table_in),
        .busy      (busy),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_index (out_index),
        .out_last  (out_last),
        .done      (done),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    typedef struct {
        logic [15:0] tbl;
        logic [31:0] stall;     // bit c set: out_ready low in cycle c
        int          first_c;   // cycle of first out_valid (0: none)
        int          last_c;    // cycle of the out_last transfer (0: none)
        logic [4:0]  last_idx;  // index carrying out_last (31: none)
        int          done_c;
        logic [4:0]  cnt;
    } vec_t;

    // Start accepted at edge 0; cycle c is the period after edge c-1.
    task automatic run_scan(input logic [15:0] t, input logic [31:0] stall,
                            output int first_c, output int last_c, output int done_c,
                            output logic [4:0] last_idx, output logic [15:0] got_mask,
                            output int unstable, output int last_flags);
        logic       prev_stall;
        logic [3:0] prev_idx;
        first_c = 0; last_c = 0; done_c = 0; last_idx = 5'd31;
        got_mask = '0; unstable = 0; last_flags = 0; prev_stall = 1'b0; prev_idx = '0;
        table_in = t;
        start    = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int c = 1; c <= 60; c++) begin
            out_ready = (c < 32) ? !stall[c] : 1'b1;
            #3;
            if (out_valid) begin
                if (first_c == 0) first_c = c;
                if (prev_stall && out_index != prev_idx) unstable++;
                if (out_ready) begin
                    got_mask[out_index] = 1'b1;
                    if (out_last) begin
                        last_flags++;
                        last_idx = {1'b0, out_index};
                        last_c   = c;
                    end
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_idx   = out_index;
            if (done) begin
                done_c = c;
                break;
            end
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        @(posedge clk);
        #4;
    endtask

    vec_t       vecs[6];
    int         fc, lc, dc, unst, lflags, seen;
    logic [4:0] li;
    logic [15:0] gm;

    initial begin
        vecs[0] = '{16'h2C80, 32'h0,   8, 14, 5'd13, 17, 5'd4};
        vecs[1] = '{16'hFFFF, 32'h0,   1, 16, 5'd15, 17, 5'd16};
        vecs[2] = '{16'h0000, 32'h0,   0,  0, 5'd31, 17, 5'd0};
        vecs[3] = '{16'h0005, 32'hE,   1,  6, 5'd2,  20, 5'd2};
        vecs[4] = '{16'h8001, 32'h2,   1, 17, 5'd15, 18, 5'd2};
        vecs[5] = '{16'h0100, 32'h600, 9, 11, 5'd8,  19, 5'd1};

        rst_n = 1'b0; start = 1'b0; table_in = '0; out_ready = 1'b1;
`ifdef MINTERM_MAXTERM_EN
        maxterm_sel = 1'b0;
`endif
        #12;
        check("reset busy",      {31'b0, busy},      32'd0);
        check("reset out_valid", {31'b0, out_valid}, 32'd0);
        check("reset done",      {31'b0, done},      32'd0);
        check("reset count",     {27'b0, count},     32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int v = 0; v < 6; v++) begin
            run_scan(vecs[v].tbl, vecs[v].stall, fc, lc, dc, li, gm, unst, lflags);
            check($sformatf("v%0d mask", v),       {16'b0, gm},             {16'b0, vecs[v].tbl});
            check($sformatf("v%0d first", v),      fc,                      vecs[v].first_c);
            check($sformatf("v%0d last cyc", v),   lc,                      vecs[v].last_c);
            check($sformatf("v%0d last idx", v),   {27'b0, li},             {27'b0, vecs[v].last_idx});
            check($sformatf("v%0d last cnt", v),   lflags,                  (vecs[v].cnt != 0) ? 1 : 0);
            check($sformatf("v%0d stable", v),     unst,                    0);
            check($sformatf("v%0d done cyc", v),   dc,                      vecs[v].done_c);
            check($sformatf("v%0d count", v),      {27'b0, count},          {27'b0, vecs[v].cnt});
            check($sformatf("v%0d idle busy", v),  {31'b0, busy},           32'd0);
        end

        // start held high through the scan and table_in changed: both ignored.
        table_in = 16'h0005; start = 1'b1;
        @(posedge clk);
        #1 table_in = 16'hFFFF;
        repeat (17) @(posedge clk);
        #1 start = 1'b0;
        #3;
        check("start ignored busy",  {31'b0, busy},  32'd0);
        check("start ignored count", {27'b0, count}, 32'd2);
        check("count hold idle",     {27'b0, count}, 32'd2);

        // Reset in cycle 9 of a 2C80 scan.
        table_in = 16'h2C80; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        check("pre-reset count", {27'b0, count}, 32'd1);
        check("pre-reset busy",  {31'b0, busy},  32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("abort busy",      {31'b0, busy},      32'd0);
        check("abort out_valid", {31'b0, out_valid}, 32'd0);
        check("abort out_last",  {31'b0, out_last},  32'd0);
        check("abort out_index", {28'b0, out_index}, 32'd0);
        check("abort count",     {27'b0, count},     32'd0);
        check("abort done",      {31'b0, done},      32'd0);
        #2 rst_n = 1'b1;
        seen = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (done || busy) seen++;
        end
        check("no done after abort", seen, 0);
        @(posedge clk);
        #1;
        run_scan(16'h2C80, 32'h0, fc, lc, dc, li, gm, unst, lflags);
        check("replay first", fc,            8);
        check("replay last",  lc,            14);
        check("replay done",  dc,            17);
        check("replay count", {27'b0, count}, 32'd4);

`ifdef MINTERM_MAXTERM_EN
        maxterm_sel = 1'b1;
        run_scan(16'hFFFE, 32'h0, fc, lc, dc, li, gm, unst, lflags);
        maxterm_sel = 1'b0;
        check("maxterm mask",  {16'b0, gm},    32'h0001);
        check("maxterm first", fc,             1);
        check("maxterm last",  lc,             1);
        check("maxterm idx",   {27'b0, li},    32'd0);
        check("maxterm done",  dc,             17);
        check("maxterm count", {27'b0, count}, 32'd1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
